mips_multicycle_ctrl: RTL and testbench

//   Main control FSM that sequences the shared MIPS datapath (one memory port, one ALU, gr file)

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/mips_multicycle_ctrl_if.sv | 39 +++
 rtl/mips_alu_decoder.sv | 32 +++
 rtl/mips_multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// datapath mux encodings, ALU operation classes and the FSM state enum.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control-path bundle between the multicycle controller (master) and the
// shared datapath (slave).
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [3:0]       alu_ctrl;
    logic             trap;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               pc_source, alu_ctrl, trap, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               pc_source, alu_ctrl, trap, retired
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// Maps the controller's ALU operation class plus the R-type funct field to
// an ALU control code; flags funct values the ALU does not implement.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       funct_valid_o
);

    // Unknown funct still drives add so the ALU sees a benign operation.
    always_comb begin
        alu_ctrl_o    = ALU_ADD;
        funct_valid_o = 1'b1;
        case (alu_op_i)
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_valid_o = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the shared-resource multicycle MIPS datapath.
// Outputs decode from state only; the sole exception is FETCH, where the
// IR and PC loads wait for the memory to return the instruction.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    mips_multicycle_ctrl_if.master  bus
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             mem_expired;
    alu_op_e          alu_op;
    logic             funct_valid;
    logic             unused_zero;

    // The zero flag gates the PC load inside the datapath, not here.
    assign unused_zero = bus.zero;
    assign mem_expired = (wait_q == TIMEOUT_LAST);
    assign bus.retired = retired_q;

    mips_alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .funct_i       (bus.funct),
        .alu_ctrl_o    (bus.alu_ctrl),
        .funct_valid_o (funct_valid)
    );

    // State, memory-wait counter and retired-instruction counter.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Next-state, wait-counter and datapath control decode.
    always_comb begin
        state_d           = state_q;
        wait_d            = wait_q;
        retire            = 1'b0;
        alu_op            = ALUOP_ADD;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.pc_source     = PCSRC_ALU;
        bus.trap          = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (mem_expired) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready)  state_d = S_MEM_WB;
                else if (mem_expired) state_d = S_TRAP;
                else                wait_d  = wait_q + 8'd1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
                retire         = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (mem_expired) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                alu_op        = ALUOP_FUNCT;
                state_d       = funct_valid ? S_ALU_WB : S_TRAP;
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                alu_op            = ALUOP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
                state_d           = S_FETCH;
                retire            = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_TRAP: begin
                bus.trap = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase

        // Any state change restarts the wait count for the next memory state.
        if (state_d != state_q) wait_d = '0;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for the multicycle MIPS controller. All
// control outputs are packed into one signature vector and compared per
// cycle against hand-written per-state expectations.
module tb_mips_multicycle_ctrl;

    logic clock;
    logic reset;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0],
    //  alu_ctrl[3:0], trap}
    logic [18:0] ctl;
    assign ctl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                  bus.alu_ctrl, bus.trap};

    localparam logic [18:0] S_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_MEM_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_MEM_RD     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_MEM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_MEM_WR     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_EXEC_ADD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_ALU_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_ADDI_EX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_ADDI_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0010,1'b0};
    localparam logic [18:0] S_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,4'b0110,1'b0};
    localparam logic [18:0] S_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,4'b0010,1'b0};
    localparam logic [18:0] S_TRAP       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0010,1'b1};

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_retired = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        reset       = 1'b0;
        exp_retired = 0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        #3;
        checks++;
        if (ctl !== S_FETCH_WAIT) begin
            $display("FAIL reset_ctl: got %h expected %h", ctl, S_FETCH_WAIT);
            errors++;
        end
        checks++;
        if (bus.retired !== 32'd0) begin
            $display("FAIL reset_retired: got %0d expected 0", bus.retired);
            errors++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [31:0] ins;
        logic [18:0] seq [5];
        ins = 32'h8C010001;
        seq = '{S_FETCH_RDY, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB};
        bus.opcode    = ins[31:26];
        bus.funct     = ins[5:0];
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== seq[i]) begin
                $display("FAIL lw_cycle%0d: got %h expected %h", i, ctl, seq[i]);
                errors++;
            end
            tick();
        end
        exp_retired++;
        checks++;
        if (bus.retired !== exp_retired || ctl !== S_FETCH_RDY) begin
            $display("FAIL lw_retire: retired=%0d ctl=%h expected %0d/%h", bus.retired, ctl, exp_retired, S_FETCH_RDY);
            errors++;
        end
    endtask

    task automatic test_add();
        logic [31:0] ins;
        logic [18:0] seq [4];
        ins = 32'h00221820;
        seq = '{S_FETCH_RDY, S_DECODE, S_EXEC_ADD, S_ALU_WB};
        bus.opcode = ins[31:26];
        bus.funct  = ins[5:0];
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== seq[i]) begin
                $display("FAIL add_cycle%0d: got %h expected %h", i, ctl, seq[i]);
                errors++;
            end
            tick();
        end
        exp_retired++;
        checks++;
        if (bus.retired !== exp_retired) begin
            $display("FAIL add_retire: got %0d expected %0d", bus.retired, exp_retired);
            errors++;
        end
    endtask

    task automatic test_sw_wait();
        logic [31:0] ins;
        logic [18:0] seq [3];
        ins = 32'hAC03FFFF;
        seq = '{S_FETCH_RDY, S_DECODE, S_MEM_ADDR};
        bus.opcode    = ins[31:26];
        bus.funct     = ins[5:0];
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== seq[i]) begin
                $display("FAIL sw_cycle%0d: got %h expected %h", i, ctl, seq[i]);
                errors++;
            end
            if (i == 2) bus.mem_ready = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (ctl !== S_MEM_WR || bus.retired !== exp_retired) begin
                $display("FAIL sw_wait%0d: ctl=%h retired=%0d expected %h/%0d", i, ctl, bus.retired, S_MEM_WR, exp_retired);
                errors++;
            end
            tick();
        end
        exp_retired++;
        checks++;
        if (bus.retired !== exp_retired || bus.trap !== 1'b0 || ctl !== S_FETCH_RDY) begin
            $display("FAIL sw_retire: retired=%0d trap=%b ctl=%h expected %0d/0/%h", bus.retired, bus.trap, ctl, exp_retired, S_FETCH_RDY);
            errors++;
        end
    endtask

    task automatic test_beq();
        logic [31:0] ins;
        logic [18:0] seq [3];
        ins = 32'h10220003;
        seq = '{S_FETCH_RDY, S_DECODE, S_BRANCH};
        bus.opcode = ins[31:26];
        bus.funct  = ins[5:0];
        bus.zero   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== seq[i]) begin
                $display("FAIL beq_cycle%0d: got %h expected %h", i, ctl, seq[i]);
                errors++;
            end
            tick();
        end
        bus.zero = 1'b0;
        exp_retired++;
        checks++;
        if (bus.retired !== exp_retired) begin
            $display("FAIL beq_retire: got %0d expected %0d", bus.retired, exp_retired);
            errors++;
        end
    endtask

    task automatic test_rtype_ops();
        logic [5:0]  fn   [4];
        logic [3:0]  code [4];
        logic [18:0] exp_exec;
        fn   = '{6'h22, 6'h24, 6'h25, 6'h2A};
        code = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
        for (int k = 0; k < 4; k++) begin
            bus.opcode = 6'h00;
            bus.funct  = fn[k];
            exp_exec   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,code[k],1'b0};
            tick();
            tick();
            checks++;
            if (ctl !== exp_exec) begin
                $display("FAIL rtype_exec funct=%h: got %h expected %h", fn[k], ctl, exp_exec);
                errors++;
            end
            tick();
            tick();
        end
        exp_retired += 4;
        checks++;
        if (bus.retired !== exp_retired) begin
            $display("FAIL rtype_retire: got %0d expected %0d", bus.retired, exp_retired);
            errors++;
        end
    endtask

    task automatic test_addi_jump();
        logic [18:0] seq_addi [4];
        logic [18:0] seq_j    [3];
        seq_addi = '{S_FETCH_RDY, S_DECODE, S_ADDI_EX, S_ADDI_WB};
        seq_j    = '{S_FETCH_RDY, S_DECODE, S_JUMP};
        bus.opcode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== seq_addi[i]) begin
                $display("FAIL addi_cycle%0d: got %h expected %h", i, ctl, seq_addi[i]);
                errors++;
            end
            tick();
        end
        bus.opcode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== seq_j[i]) begin
                $display("FAIL j_cycle%0d: got %h expected %h", i, ctl, seq_j[i]);
                errors++;
            end
            tick();
        end
        exp_retired += 2;
        checks++;
        if (bus.retired !== exp_retired) begin
            $display("FAIL addi_j_retire: got %0d expected %0d", bus.retired, exp_retired);
            errors++;
        end
    endtask

    task automatic test_trap_opcode();
        bus.opcode    = 6'h3F;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (ctl !== S_TRAP || bus.retired !== exp_retired) begin
                $display("FAIL trap_opcode%0d: ctl=%h retired=%0d expected %h/%0d", i, ctl, bus.retired, S_TRAP, exp_retired);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_trap_funct();
        logic [18:0] seq [4];
        seq = '{S_FETCH_RDY, S_DECODE, S_EXEC_ADD, S_TRAP};
        do_reset();
        bus.opcode    = 6'h00;
        bus.funct     = 6'h3F;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== seq[i]) begin
                $display("FAIL trap_funct_cycle%0d: got %h expected %h", i, ctl, seq[i]);
                errors++;
            end
            tick();
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (ctl !== S_TRAP || bus.retired !== 32'd0) begin
            $display("FAIL trap_funct_sticky: ctl=%h retired=%0d expected %h/0", ctl, bus.retired, S_TRAP);
            errors++;
        end
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ctl !== S_FETCH_WAIT) begin
                $display("FAIL timeout_wait%0d: got %h expected %h", i, ctl, S_FETCH_WAIT);
                errors++;
            end
            tick();
        end
        checks++;
        if (ctl !== S_TRAP) begin
            $display("FAIL timeout_trap: got %h expected %h", ctl, S_TRAP);
            errors++;
        end
    endtask

    task automatic test_timeout_boundary();
        do_reset();
        bus.opcode = 6'b000010;
        for (int i = 0; i < 15; i++) tick();
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== S_FETCH_RDY) begin
            $display("FAIL boundary_ready: got %h expected %h", ctl, S_FETCH_RDY);
            errors++;
        end
        tick();
        checks++;
        if (ctl !== S_DECODE) begin
            $display("FAIL boundary_no_trap: got %h expected %h", ctl, S_DECODE);
            errors++;
        end
        tick();
        tick();
        checks++;
        if (bus.retired !== 32'd1) begin
            $display("FAIL boundary_retire: got %0d expected 1", bus.retired);
            errors++;
        end
    endtask

    task automatic test_reset_mid_memwr();
        do_reset();
        bus.opcode    = 6'b101011;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        checks++;
        if (bus.mem_write !== 1'b1) begin
            $display("FAIL midwr_pre: mem_write=%b expected 1", bus.mem_write);
            errors++;
        end
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_write !== 1'b0 || ctl !== S_FETCH_WAIT) begin
            $display("FAIL midwr_reset: mem_write=%b ctl=%h expected 0/%h", bus.mem_write, ctl, S_FETCH_WAIT);
            errors++;
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_add();
        test_sw_wait();
        test_beq();
        test_rtype_ops();
        test_addi_jump();
        test_trap_opcode();
        test_trap_funct();
        test_fetch_timeout();
        test_timeout_boundary();
        test_reset_mid_memwr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
